// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: FSM state encodings, default boot PC and the
// NOP word used to clear the IF/ID instruction register.
package fetch_stage_pkg;

  typedef enum logic {
    FETCH_STATE_BOOT = 1'b0,
    FETCH_STATE_RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_START_PC = 32'h0000_0040;
  localparam logic [31:0] FETCH_NOP        = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_counters.sv
// Two saturating 32-bit event counters for the fetch stage (delivered
// instructions and bubble cycles); cleared by synchronous reset.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_fetched,
  input  logic        inc_bubble,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (inc_fetched) perf_fetched <= sat_inc(perf_fetched);
      if (inc_bubble)  perf_bubbles <= sat_inc(perf_bubbles);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// fills the IF/ID register. Optional perf counters under `FETCH_PERF_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               DBITS          = 32,
  parameter int               IMEM_ADDR_BITS = 11,
  parameter logic [DBITS-1:0] START_PC       = DBITS'(DEFAULT_START_PC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [DBITS-1:0]          redirect_pc,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  input  logic [DBITS-1:0]          imem_rdata,
  output logic                      out_valid,
  output logic [DBITS-1:0]          out_instruction,
  output logic [DBITS-1:0]          out_pc,
  output logic [DBITS-1:0]          out_pc_plus4,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_bubbles
);

  localparam logic [DBITS-1:0] PC_STEP = DBITS'(4);

  fetch_state_t     state_q, state_d;
  logic [DBITS-1:0] pc_issue;
  logic [DBITS-1:0] fetch_pc_q;
  logic [DBITS-1:0] redirect_aligned;
  logic             advance;
  logic             deliver;

  assign redirect_aligned = redirect_pc & ~DBITS'(3);

  // While stalled in RUN the same word is re-read so imem_rdata keeps
  // matching fetch_pc_q when the stall releases.
  always_comb begin
    if (redirect_valid)
      imem_addr = redirect_pc[IMEM_ADDR_BITS+1:2];
    else if (stall && state_q == FETCH_STATE_RUN)
      imem_addr = fetch_pc_q[IMEM_ADDR_BITS+1:2];
    else
      imem_addr = pc_issue[IMEM_ADDR_BITS+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH_STATE_BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    deliver = 1'b0;
    if (redirect_valid) begin
      state_d = FETCH_STATE_RUN;
    end else begin
      case (state_q)
        FETCH_STATE_BOOT: begin
          if (!stall) begin
            state_d = FETCH_STATE_RUN;
            advance = 1'b1;
          end
        end
        FETCH_STATE_RUN: begin
          if (!stall) begin
            advance = 1'b1;
            deliver = 1'b1;
          end
        end
        default: state_d = FETCH_STATE_BOOT;
      endcase
    end
  end

  // PC / IF-ID register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_issue        <= START_PC;
      fetch_pc_q      <= START_PC;
      out_valid       <= 1'b0;
      out_instruction <= DBITS'(FETCH_NOP);
      out_pc          <= '0;
      out_pc_plus4    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_aligned;
      pc_issue   <= redirect_aligned + PC_STEP;
      out_valid  <= 1'b0;
    end else if (advance) begin
      fetch_pc_q <= pc_issue;
      pc_issue   <= pc_issue + PC_STEP;
      if (deliver) begin
        out_valid       <= 1'b1;
        out_instruction <= imem_rdata;
        out_pc          <= fetch_pc_q;
        out_pc_plus4    <= fetch_pc_q + PC_STEP;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic inc_bubble;
  assign inc_bubble = !out_valid || stall;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .inc_fetched  (deliver),
    .inc_bubble   (inc_bubble),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );
`else
  assign perf_fetched = 32'd0;
  assign perf_bubbles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a 1-cycle imem whose word n holds
// 32'hA0000000 + n; perf checks follow FETCH_PERF_EN.
module tb_fetch_stage;

  localparam int DBITS          = 32;
  localparam int IMEM_ADDR_BITS = 11;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      stall;
  logic                      redirect_valid;
  logic [DBITS-1:0]          redirect_pc;
  logic [IMEM_ADDR_BITS-1:0] imem_addr;
  logic [DBITS-1:0]          imem_rdata;
  logic                      out_valid;
  logic [DBITS-1:0]          out_instruction;
  logic [DBITS-1:0]          out_pc;
  logic [DBITS-1:0]          out_pc_plus4;
  logic [31:0]               perf_fetched;
  logic [31:0]               perf_bubbles;

  int tests  = 0;
  int failed = 0;

  fetch_stage #(
    .DBITS          (DBITS),
    .IMEM_ADDR_BITS (IMEM_ADDR_BITS),
    .START_PC       (32'h0000_0040)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 32'hA000_0000 + 32'(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".pc4"}, out_pc_plus4, pc + 32'd4);
    check({tag, ".instr"}, out_instruction, instr);
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".pc"}, out_pc, 32'd0);
    check({tag, ".pc4"}, out_pc_plus4, 32'd0);
    check({tag, ".instr"}, out_instruction, 32'd0);
    check({tag, ".perf_f"}, perf_fetched, 32'd0);
    check({tag, ".perf_b"}, perf_bubbles, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    expect_reset_state("rst");
    check("rst.addr", 32'(imem_addr), 32'h10);

    // Boot: START_PC arrives on the 2nd edge after reset release
    reset = 1'b0;
    step();
    check("boot.e1.valid", 32'(out_valid), 32'd0);
    step(); expect_instr("boot.40", 32'h40, 32'hA000_0010);
    step(); expect_instr("boot.44", 32'h44, 32'hA000_0011);
    step(); expect_instr("boot.48", 32'h48, 32'hA000_0012);

    // Stall three cycles, then resume without skip or duplicate
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_instr($sformatf("stall%0d", i), 32'h48, 32'hA000_0012);
    end
    stall = 1'b0;
    step(); expect_instr("resume.4c", 32'h4C, 32'hA000_0013);
    step(); expect_instr("run.50", 32'h50, 32'hA000_0014);

    // Redirect with misaligned target: one bubble, outputs held
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    check("redir.bubble", 32'(out_valid), 32'd0);
    check("redir.hold_pc", out_pc, 32'h50);
    redirect_valid = 1'b0;
    step(); expect_instr("redir.100", 32'h100, 32'hA000_0040);
    step(); expect_instr("redir.104", 32'h104, 32'hA000_0041);

    // Redirect together with stall; stall persists into the bubble
    redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
    step();
    check("rs.bubble0", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    step(); check("rs.bubble1", 32'(out_valid), 32'd0);
    step(); check("rs.bubble2", 32'(out_valid), 32'd0);
    stall = 1'b0;
    step(); expect_instr("rs.100", 32'h100, 32'hA000_0040);
    step(); expect_instr("rs.104", 32'h104, 32'hA000_0041);

    // Back-to-back redirects: the last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); check("b2b.bubble0", 32'(out_valid), 32'd0);
    redirect_pc = 32'h300;
    step(); check("b2b.bubble1", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    step(); expect_instr("b2b.300", 32'h300, 32'hA000_00C0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); check("wrap.bubble", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    step(); expect_instr("wrap.fffc", 32'hFFFF_FFFC, 32'hA000_07FF);
    check("wrap.pc4_zero", out_pc_plus4, 32'h0);
    step(); expect_instr("wrap.0", 32'h0, 32'hA000_0000);

    // Reset while stalled and redirecting, then the boot sequence repeats
    stall = 1'b1;
    step();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    step();
    expect_reset_state("rst2");
    reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    step(); check("reboot.e1.valid", 32'(out_valid), 32'd0);
    step(); expect_instr("reboot.40", 32'h40, 32'hA000_0010);
    step(); expect_instr("reboot.44", 32'h44, 32'hA000_0011);
    step(); expect_instr("reboot.48", 32'h48, 32'hA000_0012);
    step(); expect_instr("reboot.4c", 32'h4C, 32'hA000_0013);
`ifdef FETCH_PERF_EN
    check("perf.fetched", perf_fetched, 32'd4);
    check("perf.bubbles", perf_bubbles, 32'd2);
`else
    check("perf.fetched_tied", perf_fetched, 32'd0);
    check("perf.bubbles_tied", perf_bubbles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 32-bit pipeline, directly upstream of the decode stage.
- Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Registers {valid, instruction, pc, pc+4} into the IF/ID pipeline register consumed by decode.
- Handles hazard stalls and taken-branch/JAL redirects; a redirect squashes the wrong-path instruction.

Parameters:
- DBITS, 32, data/instruction/PC width.
- IMEM_ADDR_BITS, 11, instruction-memory word-address width.
- START_PC, 32'h00000040, PC fetched after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold the IF/ID register and the PC.
- redirect_valid  input  1  branch/JAL resolved taken this cycle.
- redirect_pc  input  DBITS  target PC; bits [1:0] ignored.
- imem_addr  output  IMEM_ADDR_BITS  combinational word address into instruction memory.
- imem_rdata  input  DBITS  instruction for the address presented in the previous cycle.
- out_valid  output  1  IF/ID register holds a real instruction.
- out_instruction  output  DBITS  instruction fed to decode.
- out_pc  output  DBITS  PC of out_instruction.
- out_pc_plus4  output  DBITS  out_pc + 4 (for JAL link).
- perf_fetched  output  32  count of instructions delivered (out_valid rising into the IF/ID register while not stalled).
- perf_bubbles  output  32  count of cycles with out_valid = 0 or stall = 1.

Behaviour:
- Internal registers:
  - pc_issue: next address to issue.
  - fetch_pc_q: PC whose data arrives on imem_rdata this cycle.
  - state: BOOT or RUN. There is no separate HOLD state; hold is driven by the stall input while in RUN.
- imem_addr is selected by priority:
  1. redirect_valid: redirect_pc word address.
  2. stall and state==RUN: fetch_pc_q word address. The same word is re-read so imem_rdata stays matched to fetch_pc_q.
  3. Otherwise: pc_issue word address.
  - Word address = pc[IMEM_ADDR_BITS+1:2].
- Reset (wins over everything, including mid-stall or mid-redirect):
  - state=BOOT, pc_issue=START_PC, fetch_pc_q=START_PC.
  - out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=0, perf counters=0.
- BOOT (no redirect):
  - If stall: remain in BOOT, nothing changes.
  - Else: fetch_pc_q<=pc_issue, pc_issue<=pc_issue+4, state<=RUN. out_valid stays 0.
- RUN, no stall, no redirect:
  - out_instruction<=imem_rdata, out_pc<=fetch_pc_q, out_pc_plus4<=fetch_pc_q+4, out_valid<=1.
  - fetch_pc_q<=pc_issue, pc_issue<=pc_issue+4.
- RUN, stall, no redirect:
  - All registers hold; out_* unchanged.
- Redirect (any state, overrides stall):
  - out_valid<=0 (squash); out_instruction/out_pc/out_pc_plus4 hold.
  - fetch_pc_q<=redirect_pc & ~3, pc_issue<=(redirect_pc & ~3)+4, state<=RUN.
  - Exactly one bubble; the target instruction appears in the IF/ID register two edges after redirect.
- Latency:
  - First valid instruction (START_PC) reaches the IF/ID register on the 2nd rising edge after reset deasserts.
  - Steady state: one instruction per cycle.
- Arithmetic: all PC adds are modulo 2^DBITS; 32'hFFFFFFFC + 4 wraps to 0.
- Back-to-back redirects: each one squashes; the last one wins.
- Stall asserted on the cycle after a redirect: the bubble holds (out_valid stays 0).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: perf_fetched and perf_bubbles increment as described above, saturate at 32'hFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.
- Fetch behaviour is identical in both cases.

Decomposition:
- Shared header (alongside the Alu/Decoder constant headers) holds:
  - FETCH_STATE_BOOT / FETCH_STATE_RUN encodings.
  - START_PC default.
  - The NOP encoding used for reset of out_instruction (all zeros).
- One natural sub-module: fetch_perf_counters (two saturating counters), instantiated only under FETCH_PERF_EN.

Test Plan:
- Boot: release reset with a memory model whose word n = 32'hA0000000+n → first out_valid on edge 2 with out_pc=0x40, out_instruction=0xA0000010, out_pc_plus4=0x44; then 0x44, 0x48 on consecutive cycles.
- Stall: assert stall for 3 cycles while out_pc=0x48 → out_pc/out_instruction frozen at 0x48 for 3 cycles; next cycle out_pc=0x4C with correct data; no skipped or duplicated PC.
- Redirect: redirect_valid=1, redirect_pc=0x103 while out_pc=0x50 → next edge out_valid=0; following edge out_pc=0x100, out_pc_plus4=0x104, then 0x104.
- Redirect + stall in same cycle → redirect taken: bubble next cycle, target 0x100 delivered once stall drops.
- Wrap: redirect to 0xFFFFFFFC → out_pc=0xFFFFFFFC, out_pc_plus4=0x0, next out_pc=0x0.
- Reset mid-stall and mid-redirect → all outputs return to reset values the next edge, then the boot sequence repeats from 0x40; with FETCH_PERF_EN, counters read 0 after reset and perf_fetched=4 after four delivered instructions.
